adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin scheduler that shares one combinational 22-bit prefix adder (`adder`: `a`, `b`, `cin` -> `sum`, `cout`) among several requesters. The block sits in front of the adder and drives its operand inputs from the granted requester. It registers the adder result into a single-entry response slot tagged with the requester id. It also supports multi-word chained additions, where the carry-out of one word is fed as carry-in to the next word from the same requester while the grant is held locked.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 22, operand width; must equal the instantiated adder width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester operation valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit high per cycle
- `req_a`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  operand B, same packing
- `req_cin`  in  NREQ  carry-in, used only on the first word of a burst
- `req_chain`  in  NREQ  1 = more words follow in this burst
- `add_a`, `add_b`  out  WIDTH  operands to the shared adder
- `add_cin`  out  1  carry-in to the shared adder
- `add_sum`  in  WIDTH  adder sum, combinational from `add_a`/`add_b`/`add_cin`
- `add_cout`  in  1  adder carry-out
- `rsp_valid`  out  1  response slot full
- `rsp_ready`  in  1  consumer takes the response
- `rsp_id`  out  clog2(NREQ)  requester index of the response
- `rsp_sum`  out  WIDTH  registered sum
- `rsp_cout`  out  1  registered carry-out
- `rsp_last`  out  1  1 = final word of a burst (the accepted word had `req_chain`=0)

## Operation
- State: `IDLE` (no burst open) and `LOCK` (burst open, owner `lock_id`). Also held: round-robin pointer `ptr`, carry register `cy`, and the response slot.
- `slot_free` = !`rsp_valid` | `rsp_ready`. No grant is issued when `slot_free`=0.
- `IDLE`: the grant goes to the first i with `req_valid[i]`=1, searching `ptr`, `ptr`+1, … mod NREQ. `add_cin` = `req_cin[i]`.
- `LOCK`: only `lock_id` can be granted, and only when `req_valid[lock_id]`=1. `add_cin` = `cy`. Other requesters see `req_ready`=0 even when `lock_id` is idle, which creates a bubble.
- `add_a`/`add_b` mux the granted requester's operands. With no grant they mux the `ptr` requester in `IDLE` and `lock_id` in `LOCK`. Values driven with no grant are don't-care but must be deterministic.
- On accept (`req_valid[i]` & `req_ready[i]`):
  - Load the slot with `add_sum`, `add_cout`, id i, and `rsp_last` = !`req_chain[i]`.
  - Set `cy` <= `add_cout`.
  - If `req_chain[i]`=1: state becomes `LOCK` and `lock_id` becomes i; `ptr` is unchanged.
  - If `req_chain[i]`=0: state becomes `IDLE` and `ptr` becomes (i+1) mod NREQ.
- Slot update:
  - Accept in the same cycle as `rsp_ready` & `rsp_valid`: the slot reloads and `rsp_valid` stays 1.
  - `rsp_ready` with no accept: `rsp_valid` becomes 0.
- Arithmetic: the adder computes `sum` = (a+b+cin) mod 2^WIDTH and `cout` = bit WIDTH. The block does no arithmetic of its own.
- Reset (also mid-burst): state `IDLE`, `ptr`=0, `cy`=0, `lock_id`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_last`=0. An open burst is discarded; the requester must restart it.

## Timing
- `req_ready` is combinational from `req_valid`, state, `ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_a`/`req_b` to `req_ready`.
- Latency is 1 cycle: a word accepted at edge k appears on `rsp_*` after edge k, i.e. `rsp_valid`=1 in cycle k+1.
- Throughput is 1 word/cycle while `rsp_ready`=1.
- The critical path is operand mux -> adder -> `rsp_sum` register. This block adds no pipeline stage inside the adder.
- `rsp_*` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- When `NREQ` is not a power of two, the `ptr` wrap from NREQ-1 goes to 0.

## Test plan
- Single add: req0 with `a`=0x3FFFFF, `b`=0x000001, `cin`=0, `chain`=0 and `rsp_ready`=1. Expect `req_ready[0]`=1 in the same cycle; the next cycle shows `rsp_valid`=1, `rsp_sum`=0x000000, `rsp_cout`=1, `rsp_id`=0, `rsp_last`=1.
- Round robin: all 4 requesters hold `valid` with `chain`=0 for 8 cycles and `rsp_ready`=1. Expect grants 0,1,2,3,0,1,2,3 and `rsp_id` following the same sequence one cycle later.
- Chained 44-bit add by req2 (low word, then high word):
  - Word 1: `a`=0x3FFFFF, `b`=0x000001, `cin`=0, `chain`=1. Expect `rsp_sum`=0, `rsp_cout`=1, `rsp_last`=0.
  - Word 2: `a`=0x000005, `b`=0x000000, `chain`=0. Expect `add_cin`=1, `rsp_sum`=0x000006, `rsp_last`=1.
  - Req0/1/3 held valid during the burst are never granted; after the burst the next grant goes to req3.
- Lock bubble: req1 opens a burst (`chain`=1), then drops `valid` for 3 cycles while req0 is valid. Expect all `req_ready`=0 for those cycles. When req1 returns, its word uses `cin` from `cy`.
- Backpressure: `rsp_ready`=0 with a full slot and all requesters valid. Expect `req_ready`=0 and `rsp_*` unchanged for 5 cycles. On `rsp_ready`=1, expect pop and accept in the same cycle, with `rsp_valid` continuously 1.
- Reset mid-burst: assert `rst` asynchronously between edges while `LOCK` is held with `rsp_valid`=1. Expect `rsp_valid`=0 immediately. After release, the first `IDLE` grant goes to req0 and that word uses `req_cin`, not the stale `cy`.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin front end for one shared combinational adder. The granted
//   requester's operands drive the adder. Its result is registered into a
//   single-entry response slot tagged with the requester id. A requester can
//   issue a multi-word burst (req_chain=1 on every word but the last). The
//   grant stays locked to that requester for the whole burst, and each word's
//   carry-out becomes the next word's carry-in.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (one-hot or zero ready)
//   req_a/req_b              packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin                  carry-in for the first word of a burst
//   req_chain                more words follow from this requester
//   add_a/add_b/add_cin      operands to the shared adder
//   add_sum/add_cout         adder result (combinational from add_*)
//   rsp_valid/rsp_ready      response slot handshake
//   rsp_id/rsp_sum/rsp_cout  registered result and the owner's id
//   rsp_last                 word was the last of its burst
module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 22,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_chain,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_last
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   lock_q, lock_d;
  logic             cy_q, cy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_last_q, rsp_last_d;

  logic             slot_free;
  logic             rr_found;
  logic [IDW-1:0]   rr_id;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   mux_id;
  logic             accept;

  // (p + k) mod NREQ for p < NREQ and 0 <= k < NREQ; handles non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int t;
    t = int'(p) + k;
    if (t >= NREQ) t = t - NREQ;
    return t[IDW-1:0];
  endfunction

  assign slot_free = !rsp_valid_q || rsp_ready;

  // Round-robin search from ptr. Walking k downwards lets the lowest offset win.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(ptr_q, k)]) begin
        rr_found = 1'b1;
        rr_id    = wrap_add(ptr_q, k);
      end
    end
  end

  // When locked, only the owner may go. Other requesters are held off even
  // while the owner is idle.
  always_comb begin
    if (state_q == LOCK) begin
      gnt_id = lock_q;
      mux_id = lock_q;
      accept = slot_free && req_valid[lock_q];
    end else begin
      gnt_id = rr_id;
      mux_id = rr_id;  // equals ptr when nobody is requesting
      accept = slot_free && rr_found;
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  assign add_a   = req_a[int'(mux_id)*WIDTH +: WIDTH];
  assign add_b   = req_b[int'(mux_id)*WIDTH +: WIDTH];
  assign add_cin = (state_q == LOCK) ? cy_q : req_cin[mux_id];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    cy_d        = cy_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_last_d  = rsp_last_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_last_d  = !req_chain[gnt_id];
      cy_d        = add_cout;
      if (req_chain[gnt_id]) begin
        state_d = LOCK;
        lock_d  = gnt_id;
      end else begin
        state_d = IDLE;
        ptr_d   = wrap_add(gnt_id, 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lock_q      <= '0;
      cy_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      cy_q        <= cy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (NREQ=4, WIDTH=22) with a
// behavioural shared adder.
module tb_adder_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 22;

  logic                  clk, rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin, req_chain;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum;
  logic                  add_cin, add_cout;
  logic                  rsp_valid, rsp_ready, rsp_cout, rsp_last;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
  );

  // Shared adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setreq(input int i, input logic v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin, input logic chain);
    req_valid[i]           = v;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]             = cin;
    req_chain[i]           = chain;
  endtask

  // Move to the next rising edge and sample 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0; req_cin = '0; req_chain = '0; req_a = '0; req_b = '0;
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_sum",   32'(rsp_sum),   32'd0);
    chk("reset_rsp_id",    32'(rsp_id),    32'd0);
    chk("reset_ready",     32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;

    // Round robin: all four valid, expect 0,1,2,3,0,1,2,3
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++)
      setreq(i, 1'b1, 22'(i + 1), 22'((i + 1) * 'h100), 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
      tick();
      chk($sformatf("rr_id_%0d", c), 32'(rsp_id), 32'(c % 4));
      chk($sformatf("rr_sum_%0d", c), 32'(rsp_sum), 32'('h101 * ((c % 4) + 1)));
    end

    // Single add by req0 (ptr back at 0)
    req_valid = '0;
    setreq(0, 1'b1, 22'h3FFFFF, 22'h000001, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_add_a", 32'(add_a), 32'h3FFFFF);
    tick();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_sum",   32'(rsp_sum),   32'h0);
    chk("single_cout",  32'(rsp_cout),  32'd1);
    chk("single_id",    32'(rsp_id),    32'd0);
    chk("single_last",  32'(rsp_last),  32'd1);

    // Chained 44-bit add by req2
    req_valid = '0;
    setreq(2, 1'b1, 22'h3FFFFF, 22'h000001, 1'b0, 1'b1);
    @(negedge clk);
    chk("chain_w1_ready", 32'(req_ready), 32'h4);
    tick();
    chk("chain_w1_sum",  32'(rsp_sum),  32'h0);
    chk("chain_w1_cout", 32'(rsp_cout), 32'd1);
    chk("chain_w1_last", 32'(rsp_last), 32'd0);
    chk("chain_w1_id",   32'(rsp_id),   32'd2);
    // owner idle for one cycle, others valid: nobody granted
    setreq(0, 1'b1, 22'h11, 22'h22, 1'b0, 1'b0);
    setreq(1, 1'b1, 22'h33, 22'h44, 1'b0, 1'b0);
    setreq(3, 1'b1, 22'h55, 22'h66, 1'b0, 1'b0);
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("chain_bubble_ready", 32'(req_ready), 32'h0);
    tick();
    setreq(2, 1'b1, 22'h000005, 22'h000000, 1'b0, 1'b0);
    @(negedge clk);
    chk("chain_w2_ready", 32'(req_ready), 32'h4);
    chk("chain_w2_cin",   32'(add_cin),   32'd1);
    tick();
    chk("chain_w2_sum",  32'(rsp_sum),  32'h6);
    chk("chain_w2_last", 32'(rsp_last), 32'd1);
    chk("chain_w2_id",   32'(rsp_id),   32'd2);
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("chain_after_ready", 32'(req_ready), 32'h8);
    tick();
    chk("chain_after_id",  32'(rsp_id),  32'd3);
    chk("chain_after_sum", 32'(rsp_sum), 32'hBB);

    // Lock bubble: req1 opens a burst then idles while req0 waits
    req_valid = '0;
    setreq(1, 1'b1, 22'h3FFFFF, 22'h3FFFFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("lock_open_ready", 32'(req_ready), 32'h2);
    tick();
    chk("lock_open_sum",  32'(rsp_sum),  32'h3FFFFF);
    chk("lock_open_cout", 32'(rsp_cout), 32'd1);
    req_valid[1] = 1'b0;
    setreq(0, 1'b1, 22'h7, 22'h8, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("lock_bubble_%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    req_valid[0] = 1'b0;
    setreq(1, 1'b1, 22'h1, 22'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("lock_return_ready", 32'(req_ready), 32'h2);
    chk("lock_return_cin",   32'(add_cin),   32'd1);
    tick();
    chk("lock_return_sum", 32'(rsp_sum), 32'h4);
    chk("lock_return_id",  32'(rsp_id),  32'd1);

    // Backpressure: full slot, consumer stalled, everyone valid (ptr=2)
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++)
      setreq(i, 1'b1, 22'(i + 1), 22'((i + 1) * 'h100), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("bp_hold_%0d", c),
          32'({rsp_valid, rsp_id, rsp_last, rsp_cout, rsp_sum}),
          32'({1'b1, 2'd1, 1'b1, 1'b0, 22'h4}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'h4);
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    chk("bp_release_id",    32'(rsp_id),    32'd2);
    chk("bp_release_sum",   32'(rsp_sum),   32'h303);

    // Reset mid-burst: req3 opens a burst (carry 1), slot held full
    req_valid = '0;
    setreq(3, 1'b1, 22'h3FFFFF, 22'h000001, 1'b0, 1'b1);
    @(negedge clk);
    chk("rstb_open_ready", 32'(req_ready), 32'h8);
    tick();
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("rstb_open_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstb_async_valid", 32'(rsp_valid), 32'd0);
    chk("rstb_async_sum",   32'(rsp_sum),   32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++)
      setreq(i, 1'b1, 22'(i + 5), 22'(i + 6), 1'b0, 1'b0);
    @(negedge clk);
    chk("rstb_first_ready", 32'(req_ready), 32'h1);
    chk("rstb_first_cin",   32'(add_cin),   32'd0);
    tick();
    chk("rstb_first_sum", 32'(rsp_sum), 32'hB);
    chk("rstb_first_id",  32'(rsp_id),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
